// File: rtl/core_pkg.sv
// Shared core constants: write-back source encodings, load funct3 codes and the
// write-back source mux used by the write-back stage.
package core_pkg;

  localparam int unsigned XLEN_W  = 32;
  localparam int unsigned SRC_W   = 2;
  localparam int unsigned F3_W    = 3;
  localparam int unsigned REG_A_W = 5;

  localparam logic [SRC_W-1:0] WB_SRC_ALU = 2'b00;
  localparam logic [SRC_W-1:0] WB_SRC_MEM = 2'b01;
  localparam logic [SRC_W-1:0] WB_SRC_PC4 = 2'b10;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Encoding 11 falls back to the ALU result.
  function automatic logic [XLEN_W-1:0] wb_select(
    input logic [SRC_W-1:0]  src,
    input logic [XLEN_W-1:0] alu,
    input logic [XLEN_W-1:0] pc4,
    input logic [XLEN_W-1:0] mem
  );
    logic [XLEN_W-1:0] res;
    case (src)
      WB_SRC_MEM: res = mem;
      WB_SRC_PC4: res = pc4;
      default:    res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a memory word and sign- or
// zero-extends it according to the load funct3.
module load_align
  import core_pkg::*;
(
  input  logic [XLEN_W-1:0] rdata,
  input  logic [F3_W-1:0]   funct3,
  input  logic [1:0]        addr_lo,
  output logic [XLEN_W-1:0] ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
  end

  // Halfword select ignores addr_lo[0].
  assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_LB:   ext = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  ext = {24'h0, byte_v};
      F3_LH:   ext = {{16{half_v[15]}}, half_v};
      F3_LHU:  ext = {16'h0, half_v};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: accepts one retiring instruction per cycle, waits for load
// data when needed, and drives a registered one-cycle register-file write.
module wb_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mem_valid_i,
  output logic                 mem_ready_o,
  input  logic                 mem_reg_write_i,
  input  logic                 mem_mem_read_i,
  input  logic [SRC_W-1:0]     mem_mem_to_reg_i,
  input  logic [F3_W-1:0]      mem_funct3_i,
  input  logic [REG_A_W-1:0]   mem_rd_addr_i,
  input  logic [XLEN-1:0]      mem_alu_result_i,
  input  logic [XLEN-1:0]      mem_pc_plus4_i,
  input  logic                 dmem_rvalid_i,
  input  logic [XLEN-1:0]      dmem_rdata_i,
  output logic                 wb_reg_write_en_o,
  output logic [REG_A_W-1:0]   wb_rd_addr_o,
  output logic [XLEN-1:0]      wb_result_o
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

  wb_state_e            state, next_state;
  logic                 hold_we, next_hold_we;
  logic [REG_A_W-1:0]   hold_rd, next_hold_rd;
  logic [F3_W-1:0]      hold_f3, next_hold_f3;
  logic [1:0]           hold_addr_lo, next_hold_addr_lo;
  logic [SRC_W-1:0]     hold_src, next_hold_src;
  logic [XLEN-1:0]      hold_alt, next_hold_alt;

  logic                 next_en;
  logic [REG_A_W-1:0]   next_rd;
  logic [XLEN-1:0]      next_result;

  logic                 accept;
  logic [F3_W-1:0]      align_f3;
  logic [1:0]           align_addr_lo;
  logic [XLEN-1:0]      aligned;
  logic [XLEN-1:0]      direct_result;

  assign mem_ready_o = (state == IDLE);
  assign accept      = mem_valid_i && mem_ready_o;

  // The aligner sees held load attributes while waiting, live ones otherwise.
  assign align_f3      = (state == WAIT_LOAD) ? hold_f3 : mem_funct3_i;
  assign align_addr_lo = (state == WAIT_LOAD) ? hold_addr_lo : mem_alu_result_i[1:0];

  load_align u_load_align (
    .rdata   (dmem_rdata_i),
    .funct3  (align_f3),
    .addr_lo (align_addr_lo),
    .ext     (aligned)
  );

  assign direct_result = wb_select(mem_mem_to_reg_i, mem_alu_result_i, mem_pc_plus4_i, aligned);

  always_comb begin
    next_state        = state;
    next_en           = 1'b0;
    next_rd           = wb_rd_addr_o;
    next_result       = wb_result_o;
    next_hold_we      = hold_we;
    next_hold_rd      = hold_rd;
    next_hold_f3      = hold_f3;
    next_hold_addr_lo = hold_addr_lo;
    next_hold_src     = hold_src;
    next_hold_alt     = hold_alt;

    case (state)
      IDLE: begin
        if (accept) begin
          if (!mem_mem_read_i || dmem_rvalid_i) begin
            if (mem_reg_write_i && (mem_rd_addr_i != '0)) begin
              next_en     = 1'b1;
              next_rd     = mem_rd_addr_i;
              next_result = direct_result;
            end
          end else begin
            next_hold_we      = mem_reg_write_i;
            next_hold_rd      = mem_rd_addr_i;
            next_hold_f3      = mem_funct3_i;
            next_hold_addr_lo = mem_alu_result_i[1:0];
            next_hold_src     = mem_mem_to_reg_i;
            next_hold_alt     = wb_select(mem_mem_to_reg_i, mem_alu_result_i,
                                          mem_pc_plus4_i, '0);
            next_state        = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid_i) begin
          if (hold_we && (hold_rd != '0)) begin
            next_en     = 1'b1;
            next_rd     = hold_rd;
            next_result = (hold_src == WB_SRC_MEM) ? aligned : hold_alt;
          end
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= IDLE;
      hold_we           <= 1'b0;
      hold_rd           <= '0;
      hold_f3           <= '0;
      hold_addr_lo      <= '0;
      hold_src          <= '0;
      hold_alt          <= '0;
      wb_reg_write_en_o <= 1'b0;
      wb_rd_addr_o      <= '0;
      wb_result_o       <= '0;
    end else begin
      state             <= next_state;
      hold_we           <= next_hold_we;
      hold_rd           <= next_hold_rd;
      hold_f3           <= next_hold_f3;
      hold_addr_lo      <= next_hold_addr_lo;
      hold_src          <= next_hold_src;
      hold_alt          <= next_hold_alt;
      wb_reg_write_en_o <= next_en;
      wb_rd_addr_o      <= next_rd;
      wb_result_o       <= next_result;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: single-cycle vector table plus hand-written
// waited-load, reset-during-wait and back-to-back sequences.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic        reg_write;
  logic        mem_read;
  logic [1:0]  to_reg;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] alu;
  logic [31:0] pc4;
  logic        rvalid;
  logic [31:0] rdata;
  logic        en;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .mem_valid_i       (valid),
    .mem_ready_o       (ready),
    .mem_reg_write_i   (reg_write),
    .mem_mem_read_i    (mem_read),
    .mem_mem_to_reg_i  (to_reg),
    .mem_funct3_i      (funct3),
    .mem_rd_addr_i     (rd),
    .mem_alu_result_i  (alu),
    .mem_pc_plus4_i    (pc4),
    .dmem_rvalid_i     (rvalid),
    .dmem_rdata_i      (rdata),
    .wb_reg_write_en_o (en),
    .wb_rd_addr_o      (rd_out),
    .wb_result_o       (result)
  );

  typedef struct {
    logic        rw;
    logic        ld;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic        rv;
    logic [31:0] rdata;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic ld, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] r, input logic [31:0] a,
                       input logic [31:0] p);
    valid = v; reg_write = rw; mem_read = ld; to_reg = src;
    funct3 = f3; rd = r; alu = a; pc4 = p;
  endtask

  task automatic check_out(input string name, input logic e, input logic [4:0] r,
                           input logic [31:0] res);
    check({name, ".en"}, 32'(en), 32'(e));
    check({name, ".rd"}, 32'(rd_out), 32'(r));
    check({name, ".result"}, result, res);
  endtask

  initial begin
    //               rw  ld  src   f3    rd  alu           pc4           rv  rdata         en  rd  result
    vecs[0]  = '{1'b1,1'b0,2'b00,3'b000, 5,  32'h1234_5678,32'h0,        1'b0,32'h0,        1'b1, 5,32'h1234_5678};
    vecs[1]  = '{1'b1,1'b0,2'b00,3'b000, 0,  32'h0000_DEAD,32'h0,        1'b0,32'h0,        1'b0, 5,32'h1234_5678};
    vecs[2]  = '{1'b0,1'b0,2'b00,3'b000, 7,  32'h0000_0001,32'h0,        1'b0,32'h0,        1'b0, 5,32'h1234_5678};
    vecs[3]  = '{1'b1,1'b0,2'b10,3'b000, 9,  32'h0000_0055,32'h0000_0100,1'b0,32'h0,        1'b1, 9,32'h0000_0100};
    vecs[4]  = '{1'b1,1'b0,2'b11,3'b000,10,  32'h0000_CAFE,32'h0000_0004,1'b0,32'h0,        1'b1,10,32'h0000_CAFE};
    vecs[5]  = '{1'b1,1'b1,2'b01,3'b000,11,  32'h0000_1003,32'h0,        1'b1,32'h80FF_7F01,1'b1,11,32'hFFFF_FF80};
    vecs[6]  = '{1'b1,1'b1,2'b01,3'b100,12,  32'h0000_1003,32'h0,        1'b1,32'h80FF_7F01,1'b1,12,32'h0000_0080};
    vecs[7]  = '{1'b1,1'b1,2'b01,3'b001,13,  32'h0000_1003,32'h0,        1'b1,32'h80FF_7F01,1'b1,13,32'hFFFF_80FF};
    vecs[8]  = '{1'b1,1'b1,2'b01,3'b101,14,  32'h0000_1002,32'h0,        1'b1,32'h80FF_7F01,1'b1,14,32'h0000_80FF};
    vecs[9]  = '{1'b1,1'b1,2'b01,3'b000,15,  32'h0000_1001,32'h0,        1'b1,32'h80FF_7F01,1'b1,15,32'h0000_007F};
    vecs[10] = '{1'b1,1'b1,2'b01,3'b001,16,  32'h0000_1000,32'h0,        1'b1,32'h80FF_7F01,1'b1,16,32'h0000_7F01};
    vecs[11] = '{1'b1,1'b1,2'b01,3'b010,17,  32'h0000_1000,32'h0,        1'b1,32'h80FF_7F01,1'b1,17,32'h80FF_7F01};
    vecs[12] = '{1'b1,1'b1,2'b10,3'b000,18,  32'h0000_1000,32'h0000_0200,1'b1,32'h80FF_7F01,1'b1,18,32'h0000_0200};
    vecs[13] = '{1'b1,1'b1,2'b01,3'b011,19,  32'h0000_1002,32'h0,        1'b1,32'h80FF_7F01,1'b1,19,32'h80FF_7F01};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
    rvalid = 1'b0; rdata = 32'h0;
    #2;
    check("reset.ready", 32'(ready), 32'd1);
    check_out("reset", 1'b0, 5'd0, 32'h0);
    step();
    rst = 1'b0;

    // Table: each vector is accepted, then followed by an idle cycle with a spurious rvalid.
    for (int i = 0; i < 14; i++) begin
      check($sformatf("v%0d.ready", i), 32'(ready), 32'd1);
      drive(1'b1, vecs[i].rw, vecs[i].ld, vecs[i].src, vecs[i].f3, vecs[i].rd,
            vecs[i].alu, vecs[i].pc4);
      rvalid = vecs[i].rv; rdata = vecs[i].rdata;
      step();
      check_out($sformatf("v%0d", i), vecs[i].exp_en, vecs[i].exp_rd, vecs[i].exp_res);
      valid = 1'b0; rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
      step();
      check_out($sformatf("v%0d.idle", i), 1'b0, vecs[i].exp_rd, vecs[i].exp_res);
      rvalid = 1'b0;
    end

    // Waited LW with a second instruction held behind it.
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd20, 32'h0000_2000, 32'h0);
    rvalid = 1'b0; rdata = 32'h1122_3344;
    step();
    drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'd21, 32'h0000_AAAA, 32'h0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wait%0d.ready", k), 32'(ready), 32'd0);
      check($sformatf("wait%0d.en", k), 32'(en), 32'd0);
      if (k == 2) rvalid = 1'b1;
      step();
    end
    check_out("wait.load", 1'b1, 5'd20, 32'h1122_3344);
    check("wait.ready_back", 32'(ready), 32'd1);
    rvalid = 1'b0;
    step();
    check_out("wait.held", 1'b1, 5'd21, 32'h0000_AAAA);
    valid = 1'b0;
    step();
    check("wait.after.en", 32'(en), 32'd0);

    // Waited load with PC+4 source: the link value must survive the wait.
    drive(1'b1, 1'b1, 1'b1, 2'b10, 3'b010, 5'd22, 32'h0000_4000, 32'h0000_0300);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    step();
    check_out("wait.pc4", 1'b1, 5'd22, 32'h0000_0300);
    rvalid = 1'b0;

    // Waited LB: byte lane must come from the held address bits.
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b000, 5'd23, 32'h0000_3002, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 5'd0, 32'h0, 32'h0);
    check("wait.lb.ready", 32'(ready), 32'd0);
    step();
    rvalid = 1'b1; rdata = 32'h00AB_0000;
    step();
    check_out("wait.lb", 1'b1, 5'd23, 32'hFFFF_FFAB);
    rvalid = 1'b0;

    // Reset while waiting discards the pending load.
    drive(1'b1, 1'b1, 1'b1, 2'b01, 3'b010, 5'd24, 32'h0000_5000, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);
    check("rstw.ready_pre", 32'(ready), 32'd0);
    rst = 1'b1;
    #1;
    check("rstw.ready", 32'(ready), 32'd1);
    check_out("rstw", 1'b0, 5'd0, 32'h0);
    step();
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h7777_7777;
    step();
    check_out("rstw.late_rvalid", 1'b0, 5'd0, 32'h0);
    rvalid = 1'b0;

    // Back-to-back non-load accepts.
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 5'(25 + j), 32'h1000_0000 + 32'(j), 32'h0);
      step();
      check_out($sformatf("b2b%0d", j), 1'b1, 5'(25 + j), 32'h1000_0000 + 32'(j));
    end
    valid = 1'b0;
    step();
    check_out("b2b.end", 1'b0, 5'd28, 32'h1000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the core: terminates the MEM/WB boundary and produces the register-file write port (`wb_reg_write_en`, `wb_rd_addr`, `wb_result`) that the decode stage consumes. It accepts one retiring instruction per cycle, waits for the data-memory response on loads, aligns and sign/zero-extends load data, selects the write-back source, and drives a registered one-cycle write pulse. Back-pressure to the memory stage is via a valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk_i` input 1: core clock; all state updates on the rising edge.
- `rst_i` input 1: asynchronous, active-high reset.
- `mem_valid_i` input 1: the MEM stage presents an instruction.
- `mem_ready_o` output 1: the stage can accept; combinational, equal to (state == IDLE).
- `mem_reg_write_i` input 1: the instruction writes rd.
- `mem_mem_read_i` input 1: the instruction is a load.
- `mem_mem_to_reg_i` input 2: source select. 00 selects the ALU result, 01 selects memory, 10 selects PC+4, 11 behaves as ALU.
- `mem_funct3_i` input 3: load width/sign encoding.
- `mem_rd_addr_i` input 5: destination register.
- `mem_alu_result_i` input 32: ALU result, also the load address.
- `mem_pc_plus4_i` input 32: link value.
- `dmem_rvalid_i` input 1: load data is valid this cycle.
- `dmem_rdata_i` input 32: aligned word read from memory.
- `wb_reg_write_en_o` output 1: register-file write enable (registered).
- `wb_rd_addr_o` output 5: register-file write address (registered).
- `wb_result_o` output 32: register-file write data (registered).

## Operation
- Handshake: an instruction is accepted in a cycle when `mem_valid_i && mem_ready_o`. The MEM stage holds all `mem_*` inputs stable until that cycle.
- States: IDLE and WAIT_LOAD.
  - **IDLE, accept, not a load:** compute the result and register the outputs. Stay in IDLE.
  - **IDLE, accept, load, `dmem_rvalid_i`=1 in the same cycle:** perform a zero-wait load. Register the extended data and stay in IDLE.
  - **IDLE, accept, load, `dmem_rvalid_i`=0:** capture `rd`, `reg_write`, `funct3`, `addr[1:0]` and `mem_to_reg` into holding registers. Go to WAIT_LOAD.
  - **WAIT_LOAD, `dmem_rvalid_i`=1:** register the extended data with the held `rd` and `reg_write`. Go to IDLE.
  - **WAIT_LOAD, `dmem_rvalid_i`=0:** hold. `mem_ready_o`=0.
- `dmem_rvalid_i` is ignored in IDLE when no load is being accepted; a spurious response is dropped.
- Write enable is `reg_write && (rd != 0)`. `wb_reg_write_en_o` is 0 in every cycle that does not follow a completion.
- `wb_rd_addr_o` and `wb_result_o` keep their last values when the enable is 0.
- Load extraction uses `addr[1:0]` taken from `mem_alu_result_i`:
  - 000 (LB): byte lane `addr[1:0]`, sign-extended.
  - 100 (LBU): byte lane `addr[1:0]`, zero-extended.
  - 001 (LH): halfword `addr[1]`, sign-extended; `addr[0]` is ignored.
  - 101 (LHU): halfword `addr[1]`, zero-extended; `addr[0]` is ignored.
  - 010 (LW), and 011/110/111: the full word.
- A load with `mem_to_reg` other than 01 still waits for `rvalid`, but writes the selected non-memory source.

## Timing
- Non-load latency: accepted at edge N, so `wb_*_o` are valid in cycle N+1, for exactly one cycle.
- Load latency: the write occurs in the cycle after the `rvalid` cycle. The minimum is N+1.
- Throughput is one instruction per cycle for non-loads and zero-wait loads. Each waited load blocks acceptance until the cycle after `rvalid`, which is when `mem_ready_o` returns to 1.
- Reset values:
  - state is IDLE;
  - `mem_ready_o`=1 (including while `rst_i` is asserted);
  - `wb_reg_write_en_o`=0, `wb_rd_addr_o`=0, `wb_result_o`=0;
  - holding registers are 0.
- Reset during WAIT_LOAD discards the pending load: no write occurs, and a later `rvalid` is ignored.
- Reset deassertion is synchronised externally. The first accept is possible on the first edge after deassertion.

## Structure
- Shared `core_pkg` holds:
  - the `mem_to_reg` encoding constants (`WB_SRC_ALU`, `WB_SRC_MEM`, `WB_SRC_PC4`);
  - the load `funct3` constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
- Local `wb_state_e` enum with IDLE and WAIT_LOAD.
- One combinational sub-module, `load_align`, with inputs `rdata`, `funct3`, `addr_lo` and a 32-bit extended output.
- Everything else is inline.

## Test plan
- **ALU write:** accept rd=5, ALU=0x1234_5678, `mem_to_reg`=00 → next cycle en=1, rd=5, result=0x1234_5678. The cycle after that, en=0.
- **x0 and no-write:** rd=0 with `reg_write`=1 → en stays 0. `mem_to_reg`=10, PC+4=0x100 → result=0x0000_0100.
- **Zero-wait LB:** rdata=0x80FF_7F01, addr=0x...3, funct3=000 → result=0xFFFF_FF80. LBU → 0x0000_0080. LH at addr[1]=1 → 0xFFFF_80FF.
- **Waited load:** LW with `rvalid` arriving 3 cycles after accept.
  - `mem_ready_o`=0 for those 3 cycles; a second `mem_valid_i` is held and not accepted.
  - Write occurs the cycle after `rvalid`.
  - The held instruction is accepted in the cycle that write occurs, when `mem_ready_o` returns to 1.
- **Reset in WAIT_LOAD:** assert `rst_i` mid-wait → `mem_ready_o`=1 and en=0. A later `rvalid` produces no write.
- **Back-to-back:** four non-load accepts on consecutive cycles → four consecutive en=1 cycles with the matching rd/result, in order.
